// File: rtl/serial_transmitter.sv
// Push-button serial transmitter: start bit, 8 data bits, optional even parity, stop bit.
// Optional parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_transmitter #(
    parameter int BIT_PERIOD = 50000000,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send_key,
    input  logic [7:0] data_in,
    output logic       ser_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] LEDS
);

    localparam int CW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          key_meta_q, key_meta_d;
    logic          key_sync_q, key_sync_d;
    logic          key_prev_q, key_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
`ifdef SERIAL_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic press;
    logic bit_end;

    // Key is active-low, so a press is a falling edge of the synchronized level.
    assign press   = key_prev_q & ~key_sync_q;
    assign bit_end = (cnt_q == LAST_CNT);

    // NOTE: state registers use non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            key_meta_q <= 1'b1;
            key_sync_q <= 1'b1;
            key_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            key_meta_q <= key_meta_d;
            key_sync_q <= key_sync_d;
            key_prev_q <= key_prev_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // NOTE: every signal gets a default at the top of the block so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        key_meta_d = send_key;
        key_sync_d = key_meta_q;
        key_prev_d = key_sync_q;
        cnt_d      = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    shift_d   = data_in;
                    bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d  = ^data_in;
`endif
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = LSB_FIRST ? {1'b0, shift_q[7:1]} : {shift_q[6:0], 1'b0};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ser_out = 1'b1;
        busy    = (state_q != S_IDLE);
        done    = 1'b0;
        case (state_q)
            S_START:  ser_out = 1'b0;
            S_DATA:   ser_out = LSB_FIRST ? shift_q[0] : shift_q[7];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: ser_out = parity_q;
`endif
            S_STOP:   done = bit_end;
            default:  ser_out = 1'b1;
        endcase
    end

    assign LEDS = shift_q;

endmodule

// File: doc/serial_transmitter.md
SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

Interface
REQ-001 Parameter: BIT_PERIOD, 50000000, clock cycles per serial bit; legal range 2..2^26.
REQ-002 Parameter: LSB_FIRST, 1, data bit order: 1 = bit 0 first, 0 = bit 7 first.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: send_key  input  1  raw active-low push button; a press starts a frame.
REQ-006 Port: data_in  input  8  parallel word from switches, sampled at frame start.
REQ-007 Port: ser_out  output  1  serial line; idles high.
REQ-008 Port: busy  output  1  high while a frame is in progress.
REQ-009 Port: done  output  1  one-cycle pulse at frame completion.
REQ-010 Port: LEDS  output  8  live contents of the transmit shift register.

Function
REQ-011 send_key SHALL pass through a two-flop synchronizer; a press event is a one-cycle pulse when the synchronized level goes from 1 to 0.
REQ-012 State machine SHALL have states IDLE, START, DATA, PARITY (macro only), and STOP.
REQ-013 IDLE: ser_out=1, busy=0; on a press event, data_in is loaded into the shift register and the next state is START.
REQ-014 Each of START, DATA-bit, PARITY and STOP SHALL last exactly BIT_PERIOD cycles, timed by a bit-period counter cleared on every state or bit change.
REQ-015 START: ser_out=0.
REQ-016 DATA: 8 bits are sent in LSB_FIRST order.
REQ-017 DATA: after each bit the shift register moves one place toward the output end and a 0 is filled in; LEDS shows the register contents.
REQ-018 DATA: a 3-bit counter tracks the bits sent; after bit 8 the next state is PARITY (macro defined) or STOP.
REQ-019 STOP: ser_out=1.
REQ-020 On the last STOP cycle, done=1 for one cycle and the next state is IDLE.
REQ-021 busy SHALL be 1 in every cycle the state is not IDLE, starting the cycle after the press event.
REQ-022 Press events while busy=1 SHALL be ignored (not queued).
REQ-023 Changes on data_in while busy=1 SHALL have no effect on the frame.
REQ-024 A press event in the done cycle SHALL be ignored; a new frame needs a press event while IDLE.
REQ-025 Latency: press event in cycle N gives the ser_out falling edge in cycle N+1.
REQ-026 Frame length: (10 + parity) * BIT_PERIOD cycles.

Reset
REQ-027 When rst=1 at a clock edge: state=IDLE, ser_out=1, busy=0, done=0, LEDS=0x00, all counters=0, synchronizer flops=1.
REQ-028 Reset mid-frame SHALL abort the frame; ser_out=1 from the next cycle and done SHALL NOT pulse.
REQ-029 Reset SHALL take priority over a press event in the same cycle.

Configuration
REQ-030 Macro SERIAL_TX_PARITY_EN defined: a PARITY state of BIT_PERIOD cycles is inserted between DATA and STOP, and it sends even parity (XOR of the 8 loaded bits).
REQ-031 Macro SERIAL_TX_PARITY_EN undefined: no PARITY state or logic exists, and DATA goes directly to STOP.

Verification
REQ-032 BIT_PERIOD=4, LSB_FIRST=1, no macro, data_in=0xA5, one press -> ser_out per 4-cycle slot: 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles; done pulses once on cycle 40.
REQ-033 Same stimulus with LSB_FIRST=0 -> data slots 1,0,1,0,0,1,0,1.
REQ-034 Macro defined, data_in=0x07 -> parity slot=1; frame=44 cycles; done on cycle 44.
REQ-035 Second press during DATA, and data_in changed to 0xFF mid-frame -> frame unchanged and exactly one done pulse.
REQ-036 rst asserted for 1 cycle during bit 3 -> next cycle ser_out=1, busy=0, LEDS=0x00, no done; a new press then sends a full correct frame.
REQ-037 send_key held low for 100 cycles then released -> exactly one frame; release produces no event.
